// File: rtl/pwm_ramp_sequencer.sv
// Four-channel duty-cycle ramp controller: steps each channel's compare value
// toward its target once per tick and pushes it to the PWM over an Avalon-MM master.
module pwm_ramp_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [15:0] readdata,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [15:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;
  state_t state, state_next;

  logic [15:0] target  [4];
  logic [15:0] step    [4];
  logic [15:0] current [4];
  logic [3:0]  dirty;
  logic [15:0] tick_div, tick_cnt;
  logic        enable, irq_en, done, pending, wrote;
  logic [1:0]  ch;
  logic [15:0] nxt, nxt_calc, diff, rd_value;
  logic        tick, start, accept, advance, pass_end, needs_update, last_ch, busy;
  logic [3:0]  at_target, at_after;
  logic [1:0]  cur_sel;

  assign tick         = enable && (tick_cnt == tick_div);
  assign accept       = (state == WRITE) && !m_waitrequest;
  assign last_ch      = (ch == 2'd3);
  assign needs_update = (current[ch] != target[ch]) || dirty[ch];
  assign busy         = (state != IDLE);
  // Registers 11..14 map to channels 0..3.
  assign cur_sel      = address[1:0] + 2'd1;

  assign m_write     = (state == WRITE);
  assign m_address   = (state == WRITE) ? {2'b01, ch} : '0;
  assign m_writedata = (state == WRITE) ? nxt : '0;

  always_comb begin
    diff = (target[ch] >= current[ch]) ? target[ch] - current[ch]
                                       : current[ch] - target[ch];
    if (step[ch] == '0 || diff <= step[ch])
      nxt_calc = target[ch];
    else if (target[ch] > current[ch])
      nxt_calc = current[ch] + step[ch];
    else
      nxt_calc = current[ch] - step[ch];
  end

  // at_after reflects the compare values as they will be once this cycle's write lands.
  always_comb begin
    at_target = '0;
    at_after  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      at_target[i] = (current[i] == target[i]);
      at_after[i]  = (accept && ch == 2'(i)) ? (nxt == target[i]) : at_target[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    advance    = 1'b0;
    pass_end   = 1'b0;
    case (state)
      IDLE: begin
        if ((pending || tick) && enable) begin
          state_next = SCAN;
          start      = 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (needs_update) begin
          state_next = WRITE;
        end else begin
          advance = 1'b1;
          if (last_ch) begin
            state_next = IDLE;
            pass_end   = 1'b1;
          end
        end
      end
      WRITE: begin
        // A started transaction always runs to acceptance, even if disabled meanwhile.
        if (accept) begin
          advance  = 1'b1;
          pass_end = last_ch;
          if (!enable || last_ch) state_next = IDLE;
          else                    state_next = SCAN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_value = '0;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3:        rd_value = target[address[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7:        rd_value = step[address[1:0]];
      4'd8:                          rd_value = tick_div;
      4'd9:                          rd_value = {14'b0, irq_en, enable};
      4'd10:                         rd_value = {7'b0, done, at_target, 3'b0, busy};
      4'd11, 4'd12, 4'd13, 4'd14:    rd_value = current[cur_sel];
      default:                       rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        target[i]  <= '0;
        step[i]    <= '0;
        current[i] <= '0;
      end
      dirty    <= '0;
      tick_div <= '1;
      tick_cnt <= '0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
      wrote    <= 1'b0;
      ch       <= '0;
      nxt      <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (!enable || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 16'd1;

      if (!enable || start) pending <= 1'b0;
      else if (tick)        pending <= 1'b1;

      if (start)        ch <= '0;
      else if (advance) ch <= ch + 2'd1;

      if (state == SCAN) nxt <= nxt_calc;

      if (start)       wrote <= 1'b0;
      else if (accept) wrote <= 1'b1;

      if (accept) begin
        current[ch] <= nxt;
        dirty[ch]   <= 1'b0;
      end

      if (pass_end && (wrote || accept) && (&at_after)) done <= 1'b1;

      // Slave writes come last so they win over same-cycle master updates.
      if (write) begin
        case (address)
          4'd0, 4'd1, 4'd2, 4'd3:     target[address[1:0]] <= writedata;
          4'd4, 4'd5, 4'd6, 4'd7:     step[address[1:0]]   <= writedata;
          4'd8:                       tick_div <= writedata;
          4'd9: begin
            enable <= writedata[0];
            irq_en <= writedata[1];
          end
          4'd10:                      if (writedata[8]) done <= 1'b0;
          4'd11, 4'd12, 4'd13, 4'd14: begin
            current[cur_sel] <= writedata;
            dirty[cur_sel]   <= 1'b1;
          end
          default: ;
        endcase
      end

      if (read) readdata <= rd_value;

      irq <= done & irq_en;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed scenarios plus randomized
// configurations checked against a transaction-level ramp model.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic [15:0] readdata;
  logic        write = 1'b0;
  logic [15:0] writedata = '0;
  logic [3:0]  m_address;
  logic        m_write;
  logic [15:0] m_writedata;
  logic        m_waitrequest;
  logic        irq;

  logic force_wait = 1'b0;
  logic rand_wait  = 1'b0;
  logic rand_en    = 1'b0;
  assign m_waitrequest = force_wait | rand_wait;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [19:0] obs_q[$];
  int          acc_cyc[$];
  logic [19:0] exp_q[$];

  logic [15:0] m_tgt[4];
  logic [15:0] m_stp[4];
  logic [15:0] m_cur[4];
  logic [3:0]  m_dirty;

  pwm_ramp_sequencer dut (
    .clk(clk), .reset(reset),
    .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rand_wait = rand_en && ($urandom_range(0, 2) == 0);
  end

  // Accepted master writes; stamped with the posedge count preceding acceptance.
  initial forever begin
    @(negedge clk);
    if (m_write && !m_waitrequest) begin
      obs_q.push_back({m_address, m_writedata});
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic slv_wr(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic slv_rd(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_tgt[i] = '0; m_stp[i] = '0; m_cur[i] = '0;
    end
    m_dirty = '0;
  endtask

  task automatic set_ch(input int c, input logic [15:0] tgt, input logic [15:0] stp,
                        input bit wcur, input logic [15:0] cur);
    slv_wr(4'(c), tgt);
    slv_wr(4'(4 + c), stp);
    m_tgt[c] = tgt;
    m_stp[c] = stp;
    if (wcur) begin
      slv_wr(4'(11 + c), cur);
      m_cur[c] = cur;
      m_dirty[c] = 1'b1;
    end
  endtask

  function automatic logic [15:0] move_toward(input logic [15:0] cur, input logic [15:0] tgt,
                                              input logic [15:0] stp);
    int d;
    d = (tgt > cur) ? int'(tgt) - int'(cur) : int'(cur) - int'(tgt);
    if (stp == 0 || d <= int'(stp)) return tgt;
    return (tgt > cur) ? cur + stp : cur - stp;
  endfunction

  // Passes are replayed until nothing moves; the write order is tick-timing independent.
  task automatic build_expected();
    logic [15:0] cur[4];
    logic [3:0]  dty;
    bit          any;
    exp_q.delete();
    for (int c = 0; c < 4; c++) cur[c] = m_cur[c];
    dty = m_dirty;
    do begin
      any = 0;
      for (int c = 0; c < 4; c++) begin
        if (cur[c] != m_tgt[c] || dty[c]) begin
          cur[c] = move_toward(cur[c], m_tgt[c], m_stp[c]);
          dty[c] = 1'b0;
          exp_q.push_back({4'(4 + c), cur[c]});
          any = 1;
        end
      end
    end while (any);
  endtask

  task automatic run_model(input logic [15:0] td, input bit ie, input string tag);
    int n;
    bit done_exp;
    logic [15:0] d;
    build_expected();
    done_exp = (exp_q.size() > 0);
    obs_q.delete();
    acc_cyc.delete();
    slv_wr(4'd8, td);
    slv_wr(4'd9, {14'b0, ie, 1'b1});
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 4000) begin
      @(posedge clk); n++;
    end
    check({tag, "_timeout"}, n < 4000, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check({tag, "_write"}, obs_q[i], exp_q[i]);
    check({tag, "_irq"}, irq, ie && done_exp);
    slv_wr(4'd9, 16'h0);
    repeat (4) @(posedge clk);
    slv_rd(4'd10, d);
    check({tag, "_busy"}, d[0], 1'b0);
    check({tag, "_at_target"}, d[7:4], 4'hF);
    check({tag, "_done"}, d[8], done_exp);
    for (int c = 0; c < 4; c++) begin
      slv_rd(4'(11 + c), d);
      check({tag, "_current"}, d, m_tgt[c]);
    end
  endtask

  initial begin
    logic [15:0] d;
    int n;

    // Reset state
    do_reset();
    #1;
    check("rst_m_write", m_write, 1'b0);
    check("rst_m_address", m_address, 4'h0);
    check("rst_m_writedata", m_writedata, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", readdata, 16'h0);
    slv_rd(4'd8, d);  check("rst_tick_div", d, 16'hFFFF);
    slv_rd(4'd9, d);  check("rst_ctrl", d, 16'h0);
    slv_rd(4'd10, d); check("rst_status", d, 16'h00F0);
    slv_rd(4'd15, d); check("unmapped_rd", d, 16'h0);

    // Basic ramp with interrupt
    obs_q.delete(); acc_cyc.delete();
    slv_wr(4'd0, 16'd10);
    slv_wr(4'd4, 16'd4);
    slv_wr(4'd8, 16'd3);
    slv_wr(4'd9, 16'h3);
    n = 0;
    while (!m_write && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("first_write_lat", n, 5);
    n = 0;
    while (obs_q.size() < 3 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (!irq && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("irq_seen", irq, 1'b1);
    if (acc_cyc.size() >= 3) check("irq_lat", cyc - acc_cyc[2], 5);
    repeat (30) @(posedge clk);
    check("ramp_nwrites", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      check("ramp_w0", obs_q[0], {4'd4, 16'd4});
      check("ramp_w1", obs_q[1], {4'd4, 16'd8});
      check("ramp_w2", obs_q[2], {4'd4, 16'd10});
    end
    slv_rd(4'd10, d); check("ramp_done", d[8], 1'b1);
    slv_wr(4'd10, 16'h0100);
    check("irq_hold", irq, 1'b1);
    @(posedge clk); #1;
    check("irq_clear", irq, 1'b0);
    slv_rd(4'd10, d); check("done_clear", d[8], 1'b0);

    // Down-ramp with step 0 on a dirty channel
    do_reset();
    set_ch(1, 16'd90, 16'd0, 1, 16'd100);
    run_model(16'd3, 1'b0, "down");

    // Waitrequest stall
    do_reset();
    set_ch(2, 16'd50, 16'd20, 0, 16'd0);
    obs_q.delete();
    force_wait = 1'b1;
    slv_wr(4'd8, 16'd1);
    slv_wr(4'd9, 16'h1);
    n = 0;
    while (!m_write && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) begin
      check("wait_m_write", m_write, 1'b1);
      check("wait_m_address", m_address, 4'd6);
      check("wait_m_writedata", m_writedata, 16'd20);
      @(posedge clk); #1;
    end
    slv_rd(4'd13, d); check("wait_current_old", d, 16'd0);
    check("wait_m_write_late", m_write, 1'b1);
    check("wait_m_writedata_late", m_writedata, 16'd20);
    check("wait_no_accept", obs_q.size(), 0);
    force_wait = 1'b0;
    @(posedge clk); #1;
    check("post_accept_scan", m_write, 1'b0);
    force_wait = 1'b1;
    slv_rd(4'd13, d); check("wait_current_new", d, 16'd20);

    // Disable during a stalled write
    obs_q.delete();
    n = 0;
    while (!m_write && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("dis_data", m_writedata, 16'd40);
    slv_wr(4'd9, 16'h0);
    @(posedge clk); #1;
    check("dis_hold", m_write, 1'b1);
    force_wait = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("dis_nwrites", obs_q.size(), 1);
    if (obs_q.size() >= 1) check("dis_w0", obs_q[0], {4'd6, 16'd40});
    slv_rd(4'd10, d); check("dis_busy", d[0], 1'b0);
    slv_rd(4'd13, d); check("dis_current", d, 16'd40);

    // Reset during a stalled write
    force_wait = 1'b1;
    slv_wr(4'd9, 16'h1);
    n = 0;
    while (!m_write && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("rstw_data", m_writedata, 16'd50);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstw_m_write", m_write, 1'b0);
    check("rstw_m_address", m_address, 4'h0);
    reset = 1'b0;
    force_wait = 1'b0;
    slv_rd(4'd8, d);  check("rstw_tick_div", d, 16'hFFFF);
    slv_rd(4'd2, d);  check("rstw_target", d, 16'h0);
    slv_rd(4'd13, d); check("rstw_current", d, 16'h0);
    slv_rd(4'd9, d);  check("rstw_ctrl", d, 16'h0);
    do_reset();

    // Tick overrun: tick every cycle, all channels ramping
    for (int c = 0; c < 4; c++) set_ch(c, 16'd1000, 16'd100, 0, 16'd0);
    run_model(16'd0, 1'b0, "ovr");
    check("ovr_nacc", acc_cyc.size(), 40);
    if (acc_cyc.size() >= 40)
      for (int i = 0; i < 36; i++) check("ovr_pass_period", acc_cyc[i + 4] - acc_cyc[i], 9);

    // Randomized configurations
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_en = (r % 2) == 1;
      for (int c = 0; c < 4; c++) begin
        logic [15:0] stp;
        stp = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(100, 800));
        set_ch(c, 16'($urandom_range(0, 3000)), stp, $urandom_range(0, 1) == 1,
               16'($urandom_range(0, 3000)));
      end
      run_model(16'($urandom_range(0, 5)), $urandom_range(0, 1) == 1, "rnd");
    end
    rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
